// File: rtl/pipeline_pkg.sv
// Shared definitions for the execute stage: operation encodings and the
// state type of the iterative multiply/divide unit.
package pipeline_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_SLT   = 4'd5,
      OP_SLTU  = 4'd6,
      OP_SLL   = 4'd7,
      OP_SRL   = 4'd8,
      OP_SRA   = 4'd9,
      OP_MUL   = 4'd10,
      OP_MULHU = 4'd11,
      OP_DIVU  = 4'd12,
      OP_REMU  = 4'd13
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } md_state_e;

   function automatic logic is_muldiv(input logic [3:0] op);
      return (op >= 4'd10) && (op <= 4'd13);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) and restoring divider; one
// iteration per cycle, WIDTH iterations per operation.
import pipeline_pkg::*;

module muldiv_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             start_i,
   input  logic             is_div_i,
   input  logic             sel_hi_or_rem_i,
   input  logic [WIDTH-1:0] opa_i,
   input  logic [WIDTH-1:0] opb_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   md_state_e          state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               is_div_q, is_div_d;
   logic               sel_q, sel_d;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     rem_diff;

   // Multiply: acc = {partial, multiplier}, multiplicand held in opnd.
   // Divide: acc low half is the remainder, quo shifts dividend out / quotient in.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      rem_shift = {acc_q[WIDTH-1:0], quo_q[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, opnd_q};

      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      quo_d    = quo_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      sel_d    = sel_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d  = BUSY;
               cnt_d    = '0;
               is_div_d = is_div_i;
               sel_d    = sel_hi_or_rem_i;
               opnd_d   = is_div_i ? opb_i : opa_i;
               acc_d    = is_div_i ? '0 : {{WIDTH{1'b0}}, opb_i};
               quo_d    = is_div_i ? opa_i : '0;
            end
         end
         BUSY: begin
            cnt_d = cnt_q + CW'(1);
            if (is_div_q) begin
               if (!rem_diff[WIDTH]) begin
                  acc_d = {{WIDTH{1'b0}}, rem_diff[WIDTH-1:0]};
                  quo_d = {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = {{WIDTH{1'b0}}, rem_shift[WIDTH-1:0]};
                  quo_d = {quo_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (flush_i) state_d = IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         quo_q    <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         sel_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         quo_q    <= quo_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
         sel_q    <= sel_d;
      end
   end

   assign busy_o = (state_q != IDLE);
   assign done_o = (state_q == DONE);

   always_comb begin
      if (is_div_q) result_o = sel_q ? acc_q[WIDTH-1:0] : quo_q;
      else          result_o = sel_q ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
   end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus iterative mul/div, registered into
// the EX/MEM outputs. Stalls the front end while mul/div is in flight.
import pipeline_pkg::*;

module execute_stage #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned REG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_in,
   input  logic             flush,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic [WIDTH-1:0] store_data,
   input  logic [REG_W-1:0] RegEscr,
   output logic [WIDTH-1:0] outE,
   output logic [WIDTH-1:0] Dataout,
   output logic [REG_W-1:0] RegEscr1E,
   output logic             valid_out,
   output logic             stall
);

   logic [WIDTH-1:0] alu_res;
   logic [4:0]       shamt;
   logic             is_md, accept, md_start, md_done;
   logic [WIDTH-1:0] md_result;

   logic [WIDTH-1:0] out_q, out_d, data_q, data_d, pend_data_q, pend_data_d;
   logic [REG_W-1:0] rd_q, rd_d, pend_rd_q, pend_rd_d;
   logic             valid_q, valid_d;

   assign shamt = opB[4:0];

   // Undefined encodings fall through to ADD.
   always_comb begin
      case (op_e'(op))
         OP_SUB:  alu_res = opA - opB;
         OP_AND:  alu_res = opA & opB;
         OP_OR:   alu_res = opA | opB;
         OP_XOR:  alu_res = opA ^ opB;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (opA < opB)};
         OP_SLL:  alu_res = opA << shamt;
         OP_SRL:  alu_res = opA >> shamt;
         OP_SRA:  alu_res = $signed(opA) >>> shamt;
         default: alu_res = opA + opB;
      endcase
   end

   assign is_md    = is_muldiv(op);
   assign accept   = valid_in && !stall;
   assign md_start = accept && is_md && !flush;

   muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .flush_i         (flush),
      .start_i         (md_start),
      .is_div_i        (op[2]),
      .sel_hi_or_rem_i (op[0]),
      .opa_i           (opA),
      .opb_i           (opB),
      .busy_o          (stall),
      .done_o          (md_done),
      .result_o        (md_result)
   );

   always_comb begin
      out_d       = out_q;
      data_d      = data_q;
      rd_d        = rd_q;
      valid_d     = 1'b0;
      pend_data_d = pend_data_q;
      pend_rd_d   = pend_rd_q;

      if (flush) begin
         valid_d = 1'b0;
      end else if (md_done) begin
         out_d   = md_result;
         data_d  = pend_data_q;
         rd_d    = pend_rd_q;
         valid_d = 1'b1;
      end else if (accept) begin
         if (is_md) begin
            pend_data_d = store_data;
            pend_rd_d   = RegEscr;
         end else begin
            out_d   = alu_res;
            data_d  = store_data;
            rd_d    = RegEscr;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q       <= '0;
         data_q      <= '0;
         rd_q        <= '0;
         valid_q     <= 1'b0;
         pend_data_q <= '0;
         pend_rd_q   <= '0;
      end else begin
         out_q       <= out_d;
         data_q      <= data_d;
         rd_q        <= rd_d;
         valid_q     <= valid_d;
         pend_data_q <= pend_data_d;
         pend_rd_q   <= pend_rd_d;
      end
   end

   assign outE      = out_q;
   assign Dataout   = data_q;
   assign RegEscr1E = rd_q;
   assign valid_out = valid_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push expected
// results; a negedge monitor pops and compares whenever valid_out is high.
module tb_execute_stage;

   localparam int unsigned W  = 32;
   localparam int unsigned RW = 5;

   logic          clk, rst_n, valid_in, flush;
   logic [3:0]    op;
   logic [W-1:0]  opA, opB, store_data;
   logic [RW-1:0] RegEscr;
   logic [W-1:0]  outE, Dataout;
   logic [RW-1:0] RegEscr1E;
   logic          valid_out, stall;

   typedef struct packed {
      logic [W-1:0]  res;
      logic [RW-1:0] rd;
      logic [W-1:0]  data;
   } exp_t;

   typedef struct packed {
      logic [3:0]    op;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [RW-1:0] rd;
      logic [W-1:0]  sd;
      logic [W-1:0]  exp;
   } vec_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   execute_stage #(.WIDTH(W), .REG_W(RW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_in   (valid_in),
      .flush      (flush),
      .op         (op),
      .opA        (opA),
      .opB        (opB),
      .store_data (store_data),
      .RegEscr    (RegEscr),
      .outE       (outE),
      .Dataout    (Dataout),
      .RegEscr1E  (RegEscr1E),
      .valid_out  (valid_out),
      .stall      (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: every presented result must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (valid_out === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_result: got outE=%h rd=%0d data=%h, required no valid_out",
                        outE, RegEscr1E, Dataout);
            end else begin
               e = sb.pop_front();
               if ({outE, RegEscr1E, Dataout} !== e) begin
                  bad++;
                  $display("FAIL result: got outE=%h rd=%0d data=%h, required outE=%h rd=%0d data=%h",
                           outE, RegEscr1E, Dataout, e.res, e.rd, e.data);
               end
            end
         end
      end
   end

   task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [RW-1:0] r, input logic [W-1:0] sd,
                        input logic [W-1:0] exp, input bit has_res);
      int unsigned n = 0;
      @(negedge clk);
      op = o; opA = a; opB = b; RegEscr = r; store_data = sd; valid_in = 1'b1;
      while (stall !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (stall !== 1'b0) check("issue_timeout", {63'd0, stall}, 64'd0);
      if (has_res) sb.push_back('{exp, r, sd});
      @(posedge clk);
      #1 valid_in = 1'b0;
   endtask

   vec_t vecs[14];

   initial begin
      rst_n = 1'b0; valid_in = 1'b0; flush = 1'b0; op = '0;
      opA = '0; opB = '0; store_data = '0; RegEscr = '0;

      vecs[0]  = '{4'd9,  32'h8000_0000, 32'd31,        5'd1,  32'h0000_0001, 32'hFFFF_FFFF};
      vecs[1]  = '{4'd5,  32'hFFFF_FFFF, 32'd1,         5'd2,  32'h0000_0002, 32'h0000_0001};
      vecs[2]  = '{4'd6,  32'hFFFF_FFFF, 32'd1,         5'd3,  32'h0000_0003, 32'h0000_0000};
      vecs[3]  = '{4'd1,  32'd5,         32'd7,         5'd4,  32'hDEAD_BEEF, 32'hFFFF_FFFE};
      vecs[4]  = '{4'd2,  32'hFF00_FF00, 32'h0FF0_0FF0, 5'd6,  32'h1234_5678, 32'h0F00_0F00};
      vecs[5]  = '{4'd3,  32'hFF00_FF00, 32'h0FF0_0FF0, 5'd7,  32'h0, 32'hFFF0_FFF0};
      vecs[6]  = '{4'd7,  32'd1,         32'd31,        5'd8,  32'h0, 32'h8000_0000};
      vecs[7]  = '{4'd8,  32'h8000_0000, 32'd4,         5'd11, 32'h0, 32'h0800_0000};
      vecs[8]  = '{4'd15, 32'd3,         32'd4,         5'd12, 32'h0, 32'h0000_0007};
      vecs[9]  = '{4'd12, 32'd100,       32'd7,         5'd13, 32'hCAFE_0001, 32'd14};
      vecs[10] = '{4'd13, 32'd100,       32'd7,         5'd14, 32'hCAFE_0002, 32'd2};
      vecs[11] = '{4'd12, 32'd100,       32'd0,         5'd15, 32'hCAFE_0003, 32'hFFFF_FFFF};
      vecs[12] = '{4'd13, 32'd100,       32'd0,         5'd16, 32'hCAFE_0004, 32'd100};
      vecs[13] = '{4'd10, 32'h0001_2345, 32'h0000_0100, 5'd17, 32'hCAFE_0005, 32'h0123_4500};

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset_outputs", {outE, Dataout}, 64'd0);
      check("reset_ctrl", {55'd0, RegEscr1E, valid_out, stall}, 64'd0);

      issue(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd5, 32'hAAAA_5555, 32'h8000_0000, 1'b1);
      @(negedge clk);
      check("add_stall", {63'd0, stall}, 64'd0);

      foreach (vecs[i])
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].sd, vecs[i].exp, 1'b1);
      issue(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 32'h0, 32'h0000_0001, 1'b1);

      // MULHU latency window with an ADD held behind it
      @(negedge clk);
      while (stall !== 1'b0) @(negedge clk);
      op = 4'd11; opA = 32'hFFFF_FFFF; opB = 32'hFFFF_FFFF; RegEscr = 5'd9;
      store_data = 32'h1111_1111; valid_in = 1'b1;
      sb.push_back('{32'hFFFF_FFFE, 5'd9, 32'h1111_1111});
      @(posedge clk);
      #1 op = 4'd0; opA = 32'd1; opB = 32'd2; RegEscr = 5'd10; store_data = 32'h2222_2222;
      for (int i = 0; i < 33; i++) begin
         @(negedge clk);
         check("mulhu_stall", {63'd0, stall}, 64'd1);
         check("mulhu_bubble", {63'd0, valid_out}, 64'd0);
      end
      @(negedge clk);
      check("mulhu_stall_drop", {63'd0, stall}, 64'd0);
      sb.push_back('{32'd3, 5'd10, 32'h2222_2222});
      @(posedge clk);
      #1 valid_in = 1'b0;

      // Flush in IDLE suppresses the accepted instruction
      @(negedge clk);
      op = 4'd0; opA = 32'd9; opB = 32'd9; RegEscr = 5'd20; valid_in = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 valid_in = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("idle_flush_valid", {63'd0, valid_out}, 64'd0);

      // Flush a MUL mid-iteration (counter == 10)
      issue(4'd10, 32'd3, 32'd5, 5'd21, 32'h0, 32'd15, 1'b0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("busy_before_flush", {63'd0, stall}, 64'd1);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_stall", {63'd0, stall}, 64'd0);
      check("flush_valid", {63'd0, valid_out}, 64'd0);
      repeat (40) @(negedge clk);

      // Reset mid-DIVU
      issue(4'd12, 32'd100, 32'd7, 5'd22, 32'h5555_0000, 32'd14, 1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("midreset_outputs", {outE, Dataout}, 64'd0);
      check("midreset_ctrl", {55'd0, RegEscr1E, valid_out, stall}, 64'd0);
      issue(4'd4, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 5'd23, 32'h7777_7777, 32'h0F0F_0F0F, 1'b1);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (EX) stage of the segmented processor, directly upstream of the memory stage.
- Computes the ALU result, passes store data and destination register through, and registers all three into the EX/MEM pipeline outputs.
- Single-cycle ALU ops complete in one cycle.
- MUL/MULHU/DIVU/REMU run on an iterative shift-add / restoring-divide unit that stalls the front end for WIDTH cycles.

Parameters:
- WIDTH, 32, datapath width; also the iteration count of the mul/div unit.
- REG_W, 5, destination register index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- valid_in  input  1  ID/EX holds a valid instruction.
- flush  input  1  kill the in-flight instruction (branch redirect).
- op  input  4  operation code (encodings in package).
- opA  input  WIDTH  first operand.
- opB  input  WIDTH  second operand; shift amount = opB[4:0].
- store_data  input  WIDTH  data for a store, passed through unchanged.
- RegEscr  input  REG_W  destination register index.
- outE  output  WIDTH  registered ALU / mul / div result.
- Dataout  output  WIDTH  registered store_data.
- RegEscr1E  output  REG_W  registered destination index.
- valid_out  output  1  outE / Dataout / RegEscr1E carry a real instruction.
- stall  output  1  combinational; upstream must hold ID/EX inputs while high.

Behaviour:
- Reset: one clk edge with rst_n=0 sets outE=0, Dataout=0, RegEscr1E=0, valid_out=0, FSM=IDLE, iteration counter=0. This aborts any mul/div in flight. Reset has priority over flush, which has priority over everything else.
- Accept condition: valid_in && !stall at a rising edge.
- Single-cycle ops: ADD, SUB, AND, OR, XOR, SLT (signed), SLTU, SLL, SRL, SRA.
  - Result on outE one edge after acceptance, with valid_out=1.
  - Arithmetic wraps modulo 2^WIDTH; no overflow flag.
- No instruction accepted and FSM IDLE: valid_out=0 next cycle, other outputs hold their last value.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY on accepting a mul/div op. Operands, op, RegEscr and store_data are latched; counter=0.
  - BUSY: one iteration per cycle, counter++. After iteration WIDTH-1 (counter==WIDTH-1), go to DONE.
  - DONE: result written to outE with valid_out=1 on that edge, then go to IDLE.
- Latency: accept edge E, result visible after edge E+WIDTH+1 (33 for WIDTH=32).
- stall=1 in BUSY and DONE, 0 in IDLE. While stall=1, valid_in is ignored.
- valid_out=0 on every edge while BUSY (bubbles into MEM).
- MUL returns product[WIDTH-1:0]; MULHU returns product[2*WIDTH-1:WIDTH]. Both are unsigned.
- DIVU/REMU are unsigned. Divide by zero gives quotient all-ones and remainder = opA, with no trap; this still takes the full WIDTH cycles.
- Back-to-back: a new op may be accepted on the cycle after DONE, i.e. the first cycle stall=0.
- Flush:
  - In IDLE, flush at an edge forces valid_out=0 even if valid_in=1.
  - In BUSY/DONE, flush returns the FSM to IDLE, valid_out=0, and the result is discarded.
  - stall drops the cycle after the flush.
- Undefined op codes are treated as ADD.

Decomposition:
- pipeline_pkg: op encoding constants; FSM state typedef (IDLE/BUSY/DONE).
  - Encodings: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, MUL=10, MULHU=11, DIVU=12, REMU=13.
- Sub-module muldiv_iter:
  - Contains the FSM, counter, 2*WIDTH accumulator/remainder register and quotient register.
  - Interface: start, is_div, sel_hi_or_rem, done pulse, result.
- execute_stage contains the combinational ALU and the output registers.

Test Plan:
- Reset then ADD with opA=0x7FFFFFFF, opB=1, RegEscr=5 -> next edge outE=0x80000000, RegEscr1E=5, valid_out=1, stall=0.
- SRA with opA=0x80000000, opB=31 -> outE=0xFFFFFFFF. SLT with opA=-1, opB=1 -> outE=1. SLTU with the same operands -> outE=0.
- MULHU with opA=opB=0xFFFFFFFF accepted at edge E:
  - stall=1 and valid_out=0 from after E through E+WIDTH.
  - outE=0xFFFFFFFE with valid_out=1 after E+33.
  - A held ADD is accepted on the following edge.
- DIVU with opA=100, opB=7 -> outE=14. REMU with the same operands -> outE=2. DIVU with opA=100, opB=0 -> outE=0xFFFFFFFF. REMU with opB=0 -> outE=100.
- MUL in BUSY at counter 10, flush=1 -> next edge FSM IDLE, stall=0, valid_out=0, and no result is ever emitted.
- rst_n=0 for one edge mid-DIVU -> all outputs zero, stall=0. A subsequent XOR with opA=0xF0F0F0F0, opB=0xFFFFFFFF gives outE=0x0F0F0F0F.
